dclk_tx_multilane: RTL and testbench

//  Parametrised successor of the single-lane flit serialiser on router output ports.

---
 rtl/dclk_tx_multilane_if.sv | 12 +
 rtl/dclk_tx_multilane.sv | 185 ++++++++++++++++++
 tb/tb_dclk_tx_multilane.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dclk_tx_multilane_if.sv
// Parallel-side flit handshake between the router output arbiter and the lane serialiser.
// The arbiter drives req/parallel_in; the serialiser answers with tx_busy (FIFO full).
interface dclk_tx_multilane_if #(
    parameter int FLIT_W = 8
);
    logic              req;
    logic [FLIT_W-1:0] parallel_in;
    logic              tx_busy;

    modport master (output req, output parallel_in, input tx_busy);
    modport slave  (input req, input parallel_in, output tx_busy);
endinterface

// File: rtl/dclk_tx_multilane.sv
// Multi-lane flit serialiser: FIFO-buffered flits striped over LANES start/stop-framed lanes.
// Optional per-lane even parity bit before the stop bit when DCLK_TX_PARITY_EN is defined.
module dclk_tx_multilane #(
    parameter int FLIT_W      = 8,
    parameter int LANES       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    dclk_tx_multilane_if.slave       flit_bus,
    input  logic                     channel_busy,
    output logic [LANES-1:0]         serial_out,
    output logic                     tx_active,
    output logic                     flit_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int BEATS = FLIT_W / LANES;
`ifdef DCLK_TX_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int F     = BEATS + 2 + PAR;
    localparam int CNT_W = $clog2(F);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [3:0]             gap_cnt_reg, gap_cnt_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   busy_sync;

    logic [FLIT_W-1:0]      mem_reg [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]       level_reg;
    logic                   fifo_full, push, pop, load, can_launch;
    logic [FLIT_W-1:0]      head_flit;

    // channel_busy comes from the receiver's clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], channel_busy};
        end
    end
    assign busy_sync = sync_reg[SYNC_STAGES-1];

    assign fifo_full        = (level_reg == LVL_W'(DEPTH));
    assign flit_bus.tx_busy = fifo_full;
    assign fifo_level       = level_reg;
    assign push             = flit_bus.req & ~fifo_full;
    assign pop              = load;
    assign head_flit        = mem_reg[rd_ptr_reg];

    // Storage is not reset; only the pointers and the level define FIFO contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= flit_bus.parallel_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    assign can_launch = (level_reg != '0) && !busy_sync;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        load         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (can_launch) begin
                    load         = 1'b1;
                    state_next   = S_SEND;
                    bit_cnt_next = '0;
                end
            end
            S_SEND: begin
                if (bit_cnt_reg == CNT_W'(F - 1)) begin
                    if (GAP > 0) begin
                        state_next   = S_GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else if (can_launch) begin
                        load         = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            S_GAP: begin
                // Launching straight from the last gap cycle keeps the idle run at exactly GAP.
                if (gap_cnt_reg == '0) begin
                    if (can_launch) begin
                        load         = 1'b1;
                        state_next   = S_SEND;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign tx_active = (state_reg == S_SEND);
    assign flit_done = tx_active && (bit_cnt_reg == CNT_W'(F - 1));

    genvar gi, gk;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BEATS-1:0] lane_data;
            logic [F-1:0]     frame_load;
            logic [F-1:0]     shift_reg;

            // Lane gi takes every LANES-th flit bit starting at gi, LSB first.
            for (gk = 0; gk < BEATS; gk++) begin : g_beat
                assign lane_data[gk] = head_flit[gi + gk * LANES];
            end

`ifdef DCLK_TX_PARITY_EN
            assign frame_load = {1'b1, ^lane_data, lane_data, 1'b1};
`else
            assign frame_load = {1'b1, lane_data, 1'b1};
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shift_reg <= '0;
                end else if (load) begin
                    shift_reg <= frame_load;
                end else if (tx_active) begin
                    shift_reg <= shift_reg >> 1;
                end
            end

            assign serial_out[gi] = shift_reg[0] & tx_active;
        end
    endgenerate

endmodule

// File: tb/tb_dclk_tx_multilane.sv
// Directed bench for dclk_tx_multilane: table of flits with hand-derived lane bits,
// plus sequences for back-pressure, back-to-back, inter-frame gap and async reset.
module tb_dclk_tx_multilane;

    localparam int FLIT_W      = 8;
    localparam int LANES       = 2;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
`ifdef DCLK_TX_PARITY_EN
    localparam int F = 7;
`else
    localparam int F = 6;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dclk_tx_multilane_if #(.FLIT_W(FLIT_W)) bus_a ();
    dclk_tx_multilane_if #(.FLIT_W(FLIT_W)) bus_b ();

    logic             cb_a, cb_b;
    logic [LANES-1:0] so_a, so_b;
    logic             act_a, act_b, done_a, done_b;
    logic [2:0]       lvl_a, lvl_b;

    dclk_tx_multilane #(
        .FLIT_W(FLIT_W), .LANES(LANES), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .GAP(0)
    ) dut_a (
        .clk(clk), .reset(reset), .flit_bus(bus_a), .channel_busy(cb_a),
        .serial_out(so_a), .tx_active(act_a), .flit_done(done_a), .fifo_level(lvl_a)
    );

    dclk_tx_multilane #(
        .FLIT_W(FLIT_W), .LANES(LANES), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .GAP(3)
    ) dut_b (
        .clk(clk), .reset(reset), .flit_bus(bus_b), .channel_busy(cb_b),
        .serial_out(so_b), .tx_active(act_b), .flit_done(done_b), .fifo_level(lvl_b)
    );

    typedef struct {
        logic [7:0] flit;
        logic [3:0] d0;   // lane0 data bits, bit k = beat k
        logic [3:0] d1;   // lane1 data bits
        logic       p0;
        logic       p1;
    } vec_t;

    vec_t vecs [8];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [F-1:0] lane_frame(input vec_t v, input int lane);
        logic [3:0] d;
        logic       p;
        d = (lane == 0) ? v.d0 : v.d1;
        p = (lane == 0) ? v.p0 : v.p1;
`ifdef DCLK_TX_PARITY_EN
        return {1'b1, p, d, 1'b1};
`else
        return {1'b1, d, 1'b1} | {F{p & 1'b0}};
`endif
    endfunction

    // Caller is at the negedge of frame cycle 0; returns at the negedge of the stop-bit cycle.
    task automatic run_frame(input int sel, input vec_t v, input string tag);
        logic [F-1:0] f0, f1;
        logic [3:0]   got;
        f0 = lane_frame(v, 0);
        f1 = lane_frame(v, 1);
        for (int i = 0; i < F; i++) begin
            if (i > 0) @(negedge clk);
            got = (sel != 0) ? {done_b, act_b, so_b} : {done_a, act_a, so_a};
            check($sformatf("%s flit %02h cyc%0d", tag, v.flit, i), 32'(got),
                  32'({(i == F - 1), 1'b1, f1[i], f0[i]}));
        end
    endtask

    // Bounded wait for tx_active; leaves the caller at the negedge of frame cycle 0.
    task automatic wait_active(input int sel, input int budget, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((sel != 0) ? act_b : act_a) && n < budget);
        check({tag, " launch"}, 32'((sel != 0) ? act_b : act_a), 32'd1);
    endtask

    task automatic push_pair_a(input logic [7:0] x, input logic [7:0] y);
        bus_a.req = 1'b1; bus_a.parallel_in = x;
        @(negedge clk);
        bus_a.parallel_in = y;
        @(negedge clk);
        bus_a.req = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{8'hA5, 4'b0011, 4'b1100, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 4'b1111, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 4'b0110, 4'b0110, 1'b0, 1'b0};
        vecs[4] = '{8'h96, 4'b0110, 4'b1001, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 4'b1100, 4'b0011, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[7] = '{8'h07, 4'b0011, 4'b0001, 1'b0, 1'b1};

        bus_a.req = 1'b0; bus_a.parallel_in = '0; cb_a = 1'b0;
        bus_b.req = 1'b0; bus_b.parallel_in = '0; cb_b = 1'b0;

        #2;
        check("reset state", 32'({so_a, act_a, done_a, bus_a.tx_busy, lvl_a}), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);

        // Single flits on an idle channel.
        for (int v = 0; v < 8; v++) begin
            bus_a.req = 1'b1; bus_a.parallel_in = vecs[v].flit;
            @(negedge clk);
            bus_a.req = 1'b0;
            check($sformatf("vec%0d level/active after push", v), 32'({lvl_a, act_a}), 32'({3'd1, 1'b0}));
            @(negedge clk);
            run_frame(0, vecs[v], "vec");
            @(negedge clk);
            check($sformatf("vec%0d idle after frame", v), 32'({lvl_a, act_a, so_a}), 32'd0);
        end

        // Fill the FIFO under back-pressure; the fifth push is refused.
        cb_a = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus_a.req = 1'b1;
            bus_a.parallel_in = (k == 0) ? 8'hA5 : (k == 1) ? 8'h3C : (k == 2) ? 8'h96 : (k == 3) ? 8'h5A : 8'hFF;
            @(negedge clk);
            check($sformatf("fill push%0d level", k), 32'(lvl_a), (k < 4) ? k + 1 : 4);
            check($sformatf("fill push%0d line idle", k), 32'({act_a, so_a}), 32'd0);
        end
        bus_a.req = 1'b0;
        check("fill tx_busy", 32'(bus_a.tx_busy), 32'd1);

        // Release back-pressure: launch SYNC_STAGES+1 edges later, four contiguous frames.
        cb_a = 1'b0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
            @(negedge clk);
            check($sformatf("release wait%0d", s), 32'(act_a), 32'd0);
        end
        @(negedge clk);
        run_frame(0, vecs[0], "b2b");
        @(negedge clk); run_frame(0, vecs[3], "b2b");
        @(negedge clk); run_frame(0, vecs[4], "b2b");
        @(negedge clk); run_frame(0, vecs[5], "b2b");
        @(negedge clk);
        check("b2b drained", 32'({lvl_a, act_a, bus_a.tx_busy}), 32'd0);

        // Back-pressure raised mid-frame: frame finishes, next one waits.
        push_pair_a(8'hA5, 8'h96);
        cb_a = 1'b1;
        run_frame(0, vecs[0], "bp");
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            check($sformatf("bp held%0d", s), 32'({lvl_a, act_a, so_a}), 32'({3'd1, 1'b0, 2'b00}));
        end
        cb_a = 1'b0;
        wait_active(0, 10, "bp resume", n);
        check("bp resume edges", 32'(n), 32'(SYNC_STAGES + 1));
        run_frame(0, vecs[4], "bp");
        @(negedge clk);
        check("bp drained", 32'({lvl_a, act_a}), 32'd0);

        // GAP=3 instance: exactly three zero cycles between stop and next start.
        bus_b.req = 1'b1; bus_b.parallel_in = 8'hA5;
        @(negedge clk);
        bus_b.parallel_in = 8'h3C;
        @(negedge clk);
        bus_b.req = 1'b0;
        run_frame(1, vecs[0], "gap");
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("gap cycle%0d", s), 32'({done_b, act_b, so_b}), 32'd0);
        end
        @(negedge clk);
        run_frame(1, vecs[3], "gap");
        @(negedge clk);
        check("gap drained", 32'({lvl_b, act_b}), 32'd0);

        // Asynchronous reset at data beat 2 with a second flit still queued.
        push_pair_a(8'hA5, 8'hFF);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("abort pre-reset", 32'({act_a, so_a}), 32'({1'b1, 2'b10}));
        #1 reset = 1'b0;
        #1;
        check("abort outputs", 32'({so_a, act_a, done_a, bus_a.tx_busy, lvl_a}), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            check($sformatf("post-reset quiet%0d", s), 32'({lvl_a, act_a, so_a}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
